// File: rtl/test_vector_gen.sv
// Operand-pair stimulus source for the multiplier self-test: six directed corner
// vectors followed by NUM_RANDOM LFSR pairs, delivered over a valid/ready handshake.
module test_vector_gen #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned NUM_RANDOM = 32,
   parameter logic [31:0] SEED       = 32'hACE12345
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [7:0]       idx,
   output logic             valid,
   input  logic             ready,
   output logic             busy,
   output logic             done
);

   localparam int unsigned IDX_W  = 8;
   localparam int unsigned LFSR_W = 32;

   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [LFSR_W-1:0] POLY     = 32'h80200003;

   localparam logic [IDX_W-1:0] LAST_DIR = IDX_W'(5);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5 + NUM_RANDOM);

   localparam logic [WIDTH-1:0] OP_ZERO = '0;
   localparam logic [WIDTH-1:0] OP_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] OP_MAX  = '1;
   localparam logic [WIDTH-1:0] OP_HALF = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DIRECTED = 2'd1;
   localparam logic [1:0] ST_RANDOM   = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   logic [1:0]        state, state_nxt;
   logic [LFSR_W-1:0] lfsr, lfsr_nxt;
   logic [WIDTH-1:0]  a_nxt, b_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic              valid_nxt, busy_nxt, done_nxt;
   logic              xfer_c;
   logic [LFSR_W-1:0] lfsr_step_c;
   logic [WIDTH-1:0]  dir_a_c, dir_b_c;

   // Galois right-shift step for x^32+x^22+x^2+x+1
   assign lfsr_step_c = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
   assign xfer_c      = valid & ready;

   // Directed corner vector for the index that follows the current one
   always_comb begin
      dir_a_c = OP_ZERO;
      dir_b_c = OP_ZERO;
      case (idx + IDX_W'(1))
         IDX_W'(1): begin dir_a_c = OP_ONE;  dir_b_c = OP_ONE;  end
         IDX_W'(2): begin dir_a_c = OP_MAX;  dir_b_c = OP_MAX;  end
         IDX_W'(3): begin dir_a_c = OP_MAX;  dir_b_c = OP_ONE;  end
         IDX_W'(4): begin dir_a_c = OP_HALF; dir_b_c = OP_HALF; end
         IDX_W'(5): begin dir_a_c = OP_MAX;  dir_b_c = OP_ZERO; end
         default:   begin dir_a_c = OP_ZERO; dir_b_c = OP_ZERO; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         lfsr  <= SEED_EFF;
         a     <= '0;
         b     <= '0;
         idx   <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         lfsr  <= lfsr_nxt;
         a     <= a_nxt;
         b     <= b_nxt;
         idx   <= idx_nxt;
         valid <= valid_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lfsr_nxt  = lfsr;
      a_nxt     = a;
      b_nxt     = b;
      idx_nxt   = idx;
      valid_nxt = valid;
      busy_nxt  = busy;
      done_nxt  = done;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = ST_DIRECTED;
               lfsr_nxt  = SEED_EFF;
               a_nxt     = OP_ZERO;
               b_nxt     = OP_ZERO;
               idx_nxt   = '0;
               valid_nxt = 1'b1;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
            end
         end
         ST_DIRECTED: begin
            if (xfer_c) begin
               idx_nxt = idx + IDX_W'(1);
               if (idx == LAST_DIR) begin
                  // First random vector comes from the freshly loaded seed
                  state_nxt = ST_RANDOM;
                  a_nxt     = lfsr[WIDTH-1:0];
                  b_nxt     = lfsr[LFSR_W-1 -: WIDTH];
               end else begin
                  a_nxt = dir_a_c;
                  b_nxt = dir_b_c;
               end
            end
         end
         ST_RANDOM: begin
            if (xfer_c) begin
               idx_nxt  = idx + IDX_W'(1);
               lfsr_nxt = lfsr_step_c;
               if (idx == LAST_IDX) begin
                  state_nxt = ST_DONE;
                  valid_nxt = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  a_nxt = lfsr_step_c[WIDTH-1:0];
                  b_nxt = lfsr_step_c[LFSR_W-1 -: WIDTH];
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_test_vector_gen.sv
// Self-checking bench for test_vector_gen: expected vector list is built from the
// directed-set rules and the LFSR formula, then compared under random ready stalls.
module tb_test_vector_gen;

   localparam int unsigned WIDTH      = 16;
   localparam int unsigned NUM_RANDOM = 32;
   localparam logic [31:0] SEED       = 32'hACE12345;
   localparam int          NVEC       = 6 + NUM_RANDOM;
   localparam int          BUDGET     = 2000;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [7:0]       idx;
   logic             valid;
   logic             ready;
   logic             busy;
   logic             done;

   int checks   = 0;
   int failures = 0;

   longint unsigned exp_a [NVEC];
   longint unsigned exp_b [NVEC];

   test_vector_gen #(
      .WIDTH      (WIDTH),
      .NUM_RANDOM (NUM_RANDOM),
      .SEED       (SEED)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .idx   (idx),
      .valid (valid),
      .ready (ready),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint unsigned obs, input longint unsigned expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference list: corner vectors from M/H arithmetic, then LFSR pairs
   task automatic build_model();
      longint unsigned m, h, l, span;
      m    = (64'd1 << WIDTH) - 1;
      h    = 64'd1 << (WIDTH - 1);
      span = 64'd1 << WIDTH;
      exp_a[0] = 0; exp_b[0] = 0;
      exp_a[1] = 1; exp_b[1] = 1;
      exp_a[2] = m; exp_b[2] = m;
      exp_a[3] = m; exp_b[3] = 1;
      exp_a[4] = h; exp_b[4] = h;
      exp_a[5] = m; exp_b[5] = 0;
      l = (SEED == 0) ? 64'd1 : 64'(SEED);
      for (int k = 0; k < NUM_RANDOM; k++) begin
         exp_a[6 + k] = l % span;
         exp_b[6 + k] = l / (64'd1 << (32 - WIDTH));
         l = (l / 2) ^ (((l % 2) == 1) ? 64'h80200003 : 64'h0);
      end
   endtask

   task automatic run_seq(input bit rand_ready, input bit poke_start);
      int pos   = 0;
      int xfers = 0;
      int stall = 0;
      int cyc   = 0;
      bit xfer;
      start = 1'b1;
      ready = 1'b0;
      tick();
      start = 1'b0;
      check("done_clear", done, 0);
      while (pos < NVEC && cyc < BUDGET) begin
         check("valid", valid, 1);
         check("busy", busy, 1);
         check("idx", idx, pos);
         check("a", a, exp_a[pos]);
         check("b", b, exp_b[pos]);
         if (pos == 6) begin
            check("idx6_a", a, 64'h2345);
            check("idx6_b", b, 64'hACE1);
         end
         if (pos == 7) begin
            check("idx7_a", a, 64'h91A1);
            check("idx7_b", b, 64'hD650);
         end
         if (pos == 7 && stall < 5) begin
            ready = 1'b0;
            stall++;
         end else begin
            ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         start = poke_start && (pos == 10);
         xfer  = valid && ready;
         tick();
         cyc++;
         if (xfer) begin
            pos++;
            xfers++;
         end
      end
      start = 1'b0;
      ready = 1'b0;
      check("timeout", cyc < BUDGET, 1);
      check("xfers", xfers, NVEC);
      check("end_valid", valid, 0);
      check("end_busy", busy, 0);
      check("end_done", done, 1);
      if (!rand_ready) check("run_cycles", cyc, NVEC + 5);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      build_model();
      #2;
      check("rst_a", a, 0);
      check("rst_b", b, 0);
      check("rst_idx", idx, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      #10;
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_valid", valid, 0);

      // Back-to-back run with the idx7 stall, then random stalls with a start poke
      run_seq(1'b0, 1'b0);
      run_seq(1'b1, 1'b1);

      // ready while nothing is offered must not disturb DONE
      ready = 1'b1;
      tick();
      tick();
      tick();
      ready = 1'b0;
      check("done_hold", done, 1);
      check("done_valid", valid, 0);

      // Replay from DONE
      run_seq(1'b0, 1'b0);

      // Asynchronous reset in the middle of a run
      start = 1'b1;
      tick();
      start = 1'b0;
      ready = 1'b1;
      cyc = 0;
      while (idx != 8'd20 && cyc < BUDGET) begin
         tick();
         cyc++;
      end
      check("reach_idx20", idx, 20);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_a", a, 0);
      check("arst_b", b, 0);
      check("arst_idx", idx, 0);
      check("arst_valid", valid, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      ready = 1'b0;
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      run_seq(1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
